rf_wr_sched: RTL and testbench

RF_WR_SCHED -- requirements
Module: rf_wr_sched

---
 rtl/rf_wr_sched_if.sv | 48 ++++
 rtl/rf_wr_sched.sv | 70 +++++++
 tb/tb_rf_wr_sched.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wr_sched_if.sv
// Bundle of writeback requests, register-file write port, reservation and busy-check
// signals. The scheduler sits on the slave side.
interface rf_wr_sched_if #(
  parameter int unsigned pw = 4
);
  logic          req0_valid;
  logic [pw-1:0] req0_addr;
  logic [7:0]    req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [pw-1:0] req1_addr;
  logic [7:0]    req1_data;
  logic          req1_ready;
  logic          rf_wr_en;
  logic [pw-1:0] rf_wr_addr;
  logic [7:0]    rf_dat_in;
  logic          rsv_en;
  logic [pw-1:0] rsv_addr;
  logic          rsv_ok;
  logic [pw-1:0] rd_addrA;
  logic [pw-1:0] rd_addrB;
  logic          busyA;
  logic          busyB;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_wr_en, rf_wr_addr, rf_dat_in,
    input  rsv_en, rsv_addr,
    output rsv_ok,
    input  rd_addrA, rd_addrB,
    output busyA, busyB
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_wr_en, rf_wr_addr, rf_dat_in,
    output rsv_en, rsv_addr,
    input  rsv_ok,
    output rd_addrA, rd_addrB,
    input  busyA, busyB
  );
endinterface

// File: rtl/rf_wr_sched.sv
// Register-file write scheduler: round-robin arbitration of two writeback sources onto
// one registered write port, plus a busy-bit scoreboard for destination reservations.
module rf_wr_sched #(
  parameter int unsigned pw = 4
) (
  input logic         clk,
  input logic         reset,
  rf_wr_sched_if.slave bus
);
  localparam int unsigned NumRegs = 2 ** pw;

  logic               r_pri;
  logic               r_wr_en;
  logic [pw-1:0]      r_wr_addr;
  logic [7:0]         r_wr_data;
  logic [NumRegs-1:0] r_busy;

  logic               w_ready0;
  logic               w_ready1;
  logic               w_accept;
  logic               w_rsv_ok;
  logic [NumRegs-1:0] w_busy_d;

  // Readies are forced low while reset is held so nothing is accepted.
  always_comb begin
    w_ready0 = ~reset & bus.req0_valid & (~r_pri | ~bus.req1_valid);
    w_ready1 = ~reset & bus.req1_valid & (r_pri | ~bus.req0_valid);
    w_accept = w_ready0 | w_ready1;
    w_rsv_ok = ~r_busy[bus.rsv_addr];
  end

  // Clear from the commit first, then the reservation so a same-edge set wins.
  always_comb begin
    w_busy_d = r_busy;
    if (r_wr_en) begin
      w_busy_d[r_wr_addr] = 1'b0;
    end
    if (bus.rsv_en && w_rsv_ok) begin
      w_busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pri     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= '0;
    end else begin
      r_wr_en <= w_accept;
      r_busy  <= w_busy_d;
      if (w_accept) begin
        r_pri     <= w_ready0;
        r_wr_addr <= w_ready0 ? bus.req0_addr : bus.req1_addr;
        r_wr_data <= w_ready0 ? bus.req0_data : bus.req1_data;
      end
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rf_wr_en   = r_wr_en;
  assign bus.rf_wr_addr = r_wr_addr;
  assign bus.rf_dat_in  = r_wr_data;
  assign bus.rsv_ok     = w_rsv_ok;
  assign bus.busyA      = r_busy[bus.rd_addrA];
  assign bus.busyB      = r_busy[bus.rd_addrB];

endmodule

// File: tb/tb_rf_wr_sched.sv
// Bench for rf_wr_sched: directed scenarios then randomized traffic, with a queue-based
// scoreboard for register-file writes and a per-cycle model of grants and busy bits.
module tb_rf_wr_sched;
  localparam int unsigned PW = 4;
  localparam int unsigned NR = 2 ** PW;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [7:0]    data;
    int unsigned   due;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  wr_t sb[$];

  // Reference state: who has priority, which registers are reserved, pending commit.
  bit          m_pri;
  bit [NR-1:0] m_busy;
  bit          m_wr_pend;
  bit [PW-1:0] m_wr_addr;

  rf_wr_sched_if #(.pw(PW)) bus ();

  rf_wr_sched #(.pw(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rf_wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_wr_en", 32'(bus.rf_wr_en), 32'd0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", 32'(bus.rf_wr_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.rf_dat_in), 32'(e.data));
          chk("wr_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("missing_wr_en", 32'(bus.rf_wr_en), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    bus.rd_addrA = '0; bus.rd_addrB = '0;
  endtask

  task automatic model_reset();
    sb.delete();
    m_pri = 1'b0;
    m_busy = '0;
    m_wr_pend = 1'b0;
    m_wr_addr = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    model_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
    chk("rst_dat_in", 32'(bus.rf_dat_in), 32'd0);
    drive_idle();
    reset = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic do_cycle(input bit v0, input bit [PW-1:0] a0, input bit [7:0] d0,
                          input bit v1, input bit [PW-1:0] a1, input bit [7:0] d1,
                          input bit re, input bit [PW-1:0] ra,
                          input bit [PW-1:0] rda, input bit [PW-1:0] rdb,
                          output bit g0, output bit g1);
    bit ok;
    @(posedge clk);
    #1;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.rsv_en = re; bus.rsv_addr = ra;
    bus.rd_addrA = rda; bus.rd_addrB = rdb;
    @(negedge clk);
    g0 = v0 && (m_pri == 1'b0 || !v1);
    g1 = v1 && (m_pri == 1'b1 || !v0);
    ok = !m_busy[ra];
    chk("ready0", 32'(bus.req0_ready), 32'(g0));
    chk("ready1", 32'(bus.req1_ready), 32'(g1));
    chk("busyA", 32'(bus.busyA), 32'(m_busy[rda]));
    chk("busyB", 32'(bus.busyB), 32'(m_busy[rdb]));
    chk("rsv_ok", 32'(bus.rsv_ok), 32'(ok));
    if (g0) sb.push_back('{addr: a0, data: d0, due: cyc + 1});
    if (g1) sb.push_back('{addr: a1, data: d1, due: cyc + 1});
    if (m_wr_pend) m_busy[m_wr_addr] = 1'b0;
    if (re && ok) m_busy[ra] = 1'b1;
    m_wr_pend = g0 || g1;
    m_wr_addr = g0 ? a0 : a1;
    if (g0) m_pri = 1'b1;
    else if (g1) m_pri = 1'b0;
  endtask

  task automatic idle(input bit [PW-1:0] rda, output bit g0, output bit g1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, rda, rda, g0, g1);
  endtask

  initial begin
    bit g0, g1;
    bit c_v0, c_v1, re;
    bit [PW-1:0] c_a0, c_a1, ra, rda, rdb;
    bit [7:0] c_d0, c_d1;

    drive_idle();
    apply_reset();

    // Single ALU write: one-cycle latency, single pulse.
    do_cycle(1, 3, 8'h5A, 0, 0, 0, 0, 0, 3, 3, g0, g1);
    chk("single_grant_ready0", 32'(bus.req0_ready), 32'd1);
    idle(3, g0, g1);
    chk("single_wr_en", 32'(bus.rf_wr_en), 32'd1);
    chk("single_wr_addr", 32'(bus.rf_wr_addr), 32'd3);
    chk("single_dat_in", 32'(bus.rf_dat_in), 32'h5A);
    chk("nonbusy_write_stays_free", 32'(bus.busyA), 32'd0);
    idle(3, g0, g1);
    chk("single_wr_en_drop", 32'(bus.rf_wr_en), 32'd0);

    // Both requesters held: grants alternate starting from requester 0.
    apply_reset();
    do_cycle(1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, g0, g1);
    do_cycle(1, 4, 8'h44, 1, 2, 8'h22, 0, 0, 0, 0, g0, g1);
    do_cycle(1, 4, 8'h44, 1, 6, 8'h66, 0, 0, 0, 0, g0, g1);
    do_cycle(1, 8, 8'h88, 1, 6, 8'h66, 0, 0, 0, 0, g0, g1);
    repeat (2) idle(0, g0, g1);

    // Reserve 7, duplicate reservation ignored, commit clears it.
    do_cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, g0, g1);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 7, g0, g1);
    chk("dup_rsv_ok_low", 32'(bus.rsv_ok), 32'd0);
    chk("rsv7_busyA", 32'(bus.busyA), 32'd1);
    do_cycle(0, 0, 0, 1, 7, 8'h77, 0, 0, 7, 7, g0, g1);
    idle(7, g0, g1);
    chk("commit7_still_busy", 32'(bus.busyA), 32'd1);
    idle(7, g0, g1);
    chk("commit7_cleared", 32'(bus.busyA), 32'd0);

    // Commit and reservation of reg 5 on the same edge: set wins.
    do_cycle(1, 5, 8'h55, 0, 0, 0, 0, 0, 5, 5, g0, g1);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5, 5, 5, g0, g1);
    idle(5, g0, g1);
    chk("same_edge_set_wins", 32'(bus.busyA), 32'd1);

    // Same address from both sources: later grant written last.
    do_cycle(1, 9, 8'hA0, 1, 9, 8'hB1, 0, 0, 9, 9, g0, g1);
    do_cycle(0, 0, 0, 1, 9, 8'hB1, 1, 2, 9, 2, g0, g1);
    idle(9, g0, g1);
    chk("same_addr_last_data", 32'(bus.rf_dat_in), 32'hB1);

    // Accept then reset next cycle: pending write dropped immediately.
    do_cycle(1, 12, 8'hC3, 1, 13, 8'hD4, 1, 12, 0, 0, g0, g1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_kills_wr_en", 32'(bus.rf_wr_en), 32'd0);
    apply_reset();
    for (int i = 0; i < int'(NR); i += 2) begin
      idle(PW'(i), g0, g1);
      do_cycle(0, 0, 0, 0, 0, 0, 0, 0, PW'(i + 1), PW'(i), g0, g1);
    end
    do_cycle(1, 1, 8'h01, 1, 2, 8'h02, 0, 0, 0, 0, g0, g1);
    chk("post_reset_pri0", 32'(bus.req0_ready), 32'd1);

    // Randomized traffic; an ungranted requester keeps its request stable.
    c_v0 = 0; c_v1 = 0; g0 = 0; g1 = 0;
    c_a0 = 0; c_a1 = 0; c_d0 = 0; c_d1 = 0;
    for (int n = 0; n < 500; n++) begin
      if (!(c_v0 && !g0)) begin
        c_v0 = ($urandom_range(0, 3) != 0);
        c_a0 = PW'($urandom_range(0, NR - 1));
        c_d0 = 8'($urandom_range(0, 255));
      end
      if (!(c_v1 && !g1)) begin
        c_v1 = ($urandom_range(0, 3) != 0);
        c_a1 = PW'($urandom_range(0, NR - 1));
        c_d1 = 8'($urandom_range(0, 255));
      end
      re  = ($urandom_range(0, 2) == 0);
      ra  = PW'($urandom_range(0, NR - 1));
      rda = PW'($urandom_range(0, NR - 1));
      rdb = PW'($urandom_range(0, NR - 1));
      do_cycle(c_v0, c_a0, c_d0, c_v1, c_a1, c_d1, re, ra, rda, rdb, g0, g1);
    end
    repeat (3) idle(0, g0, g1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
